// File: rtl/scaled_frame_buffer.sv
// Multi-buffered source frame store with integer up-scaled, palette-mapped readout.
// Define SCALED_FRAME_BUFFER_ROTATE_180_EN to display the frame rotated by 180 degrees.
module scaled_frame_buffer #(
    parameter int SRC_W   = 160,
    parameter int SRC_H   = 144,
    parameter int PIX_W   = 2,
    parameter int SCALE   = 3,
    parameter int NUM_BUF = 3,
    parameter int COLOR_W = 16
) (
    input  logic                            pclk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [PIX_W-1:0]                in_pixel,
    input  logic                            in_vsync,
    input  logic [COLOR_W*(2**PIX_W)-1:0]   palette,
    input  logic                            de,
    input  logic                            hsync,
    input  logic                            vsync,
    output logic [COLOR_W-1:0]              color,
    output logic                            out_de,
    output logic [7:0]                      drop_cnt
);

    localparam int DEPTH = SRC_W * SRC_H;
    localparam int AW    = $clog2(DEPTH);
    localparam int WAW   = $clog2(DEPTH + 1);
    localparam int XW    = $clog2(SRC_W + 1);
    localparam int YW    = $clog2(SRC_H + 1);
    localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int BW    = 2;

    localparam logic [WAW-1:0] FULL   = WAW'(DEPTH);
    localparam logic [XW-1:0]  X_MAX  = XW'(SRC_W);
    localparam logic [YW-1:0]  Y_MAX  = YW'(SRC_H);
    localparam logic [SW-1:0]  S_LAST = SW'(SCALE - 1);

    if (NUM_BUF < 3 || NUM_BUF > 4) begin : g_bad_num_buf
        $error("NUM_BUF must be 3 or 4");
    end

    logic [PIX_W-1:0] mem [NUM_BUF][DEPTH];

    logic [WAW-1:0] waddr;
    logic [BW-1:0]  wb;
    logic [BW-1:0]  lc;
    logic [BW-1:0]  rb;
    logic           have_frame;

    logic in_vsync_q;
    logic hsync_q;
    logic vsync_q;
    logic de_q;

    logic [XW-1:0] x;
    logic [SW-1:0] xs;
    logic [YW-1:0] y;
    logic [SW-1:0] ys;

    logic [PIX_W-1:0]   rd_pix;
    logic               act1;
    logic               de1;
    logic [COLOR_W-1:0] pal_sel;

    logic           vs_rise;
    logic           frame_done;
    logic           frame_drop;
    logic           rd_swap;
    logic           hs_fall;
    logic           de_fall;
    logic [BW-1:0]  lc_next;
    logic [BW-1:0]  rb_next;
    logic [BW-1:0]  wb_free;
    logic [BW-1:0]  wb_next;
    logic [WAW-1:0] wr_addr;
    logic           wr_en;
    logic           active;
    logic [AW-1:0]  ax;
    logic [AW-1:0]  ay;
    logic [AW-1:0]  rd_addr;

    always_comb begin
        vs_rise    = in_vsync & ~in_vsync_q;
        frame_done = vs_rise & (waddr == FULL);
        frame_drop = vs_rise & (waddr != '0) & (waddr != FULL);
        rd_swap    = ~vsync & vsync_q;
        hs_fall    = ~hsync & hsync_q;
        de_fall    = ~de & de_q;
        lc_next    = frame_done ? wb : lc;
        rb_next    = rd_swap ? lc : rb;
    end

    // Lowest buffer not being displayed and not holding the newest frame.
    always_comb begin
        wb_free = wb;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (BW'(i) != rb_next && BW'(i) != lc_next) begin
                wb_free = BW'(i);
            end
        end
    end

    always_comb begin
        wb_next = frame_done ? wb_free : wb;
        wr_addr = (vs_rise && waddr != '0) ? '0 : waddr;
        wr_en   = in_valid & (wr_addr != FULL);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            waddr      <= '0;
            wb         <= BW'(0);
            lc         <= BW'(1);
            rb         <= BW'(1);
            have_frame <= 1'b0;
            drop_cnt   <= 8'd0;
            in_vsync_q <= 1'b0;
        end else begin
            in_vsync_q <= in_vsync;
            wb         <= wb_next;
            lc         <= lc_next;
            rb         <= rb_next;
            if (frame_done) begin
                have_frame <= 1'b1;
            end
            waddr <= wr_en ? wr_addr + WAW'(1) : wr_addr;
            if (frame_drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem[wb_next][wr_addr[AW-1:0]] <= in_pixel;
        end
    end

    always_comb begin
        active = de & (x < X_MAX) & (y < Y_MAX);
`ifdef SCALED_FRAME_BUFFER_ROTATE_180_EN
        ax = AW'(SRC_W - 1) - AW'(x);
        ay = AW'(SRC_H - 1) - AW'(y);
`else
        ax = AW'(x);
        ay = AW'(y);
`endif
        // Blanked samples read address 0 so the index never leaves the array.
        rd_addr = active ? ay * AW'(SRC_W) + ax : '0;
        pal_sel = palette[int'(rd_pix) * COLOR_W +: COLOR_W];
    end

    always_ff @(posedge pclk) begin
        rd_pix <= mem[rb][rd_addr];
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            xs      <= '0;
            y       <= '0;
            ys      <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            act1    <= 1'b0;
            de1     <= 1'b0;
            color   <= '0;
            out_de  <= 1'b0;
        end else begin
            hsync_q <= hsync;
            vsync_q <= vsync;
            de_q    <= de;
            de1     <= de;
            out_de  <= de1;
            act1    <= active & have_frame;
            color   <= act1 ? pal_sel : '0;
            if (rd_swap) begin
                x  <= '0;
                xs <= '0;
                y  <= '0;
                ys <= '0;
            end else begin
                if (hs_fall) begin
                    x  <= '0;
                    xs <= '0;
                end else if (de) begin
                    if (xs == S_LAST) begin
                        xs <= '0;
                        if (x != X_MAX) begin
                            x <= x + XW'(1);
                        end
                    end else begin
                        xs <= xs + SW'(1);
                    end
                end
                if (de_fall) begin
                    if (ys == S_LAST) begin
                        ys <= '0;
                        if (y != Y_MAX) begin
                            y <= y + YW'(1);
                        end
                    end else begin
                        ys <= ys + SW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_scaled_frame_buffer.sv
// Self-checking bench for scaled_frame_buffer: buffer rotation, drop counting,
// scaled palette readout via a colour scoreboard, and asynchronous reset.
module tb_scaled_frame_buffer;

    localparam int SRC_W   = 160;
    localparam int SRC_H   = 144;
    localparam int PIX_W   = 2;
    localparam int SCALE   = 3;
    localparam int NUM_BUF = 3;
    localparam int COLOR_W = 16;
    localparam int DEPTH   = SRC_W * SRC_H;

    logic        pclk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_pixel;
    logic        in_vsync;
    logic [63:0] palette;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [15:0] color;
    logic        out_de;
    logic [7:0]  drop_cnt;

    logic [15:0] pal_tab [4] = '{16'h1234, 16'h0F0F, 16'h5A5A, 16'hC3A5};

    int errors = 0;
    int checks = 0;
    bit sb_en  = 1'b0;
    logic [15:0] sbq [$];

    typedef struct {
        int npix;
        int exp_drop;
    } drop_vec_t;

    drop_vec_t tv [4];

    always #5 pclk = ~pclk;

    scaled_frame_buffer #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .PIX_W(PIX_W),
        .SCALE(SCALE), .NUM_BUF(NUM_BUF), .COLOR_W(COLOR_W)
    ) dut (
        .pclk(pclk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_vsync(in_vsync), .palette(palette), .de(de), .hsync(hsync),
        .vsync(vsync), .color(color), .out_de(out_de), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pix(input int fr, input int mx, input int my);
        if (fr == 1) return (mx + 2 * my) & 3;
        return (mx == 0 && my == 0) ? 3 : 2;
    endfunction

    function automatic logic [15:0] exp_color(input int fr, input int ln, input int c);
        int sx, sy, mx, my;
        sx = c / SCALE;
        sy = ln / SCALE;
        if (sx >= SRC_W || sy >= SRC_H) return 16'h0000;
`ifdef SCALED_FRAME_BUFFER_ROTATE_180_EN
        mx = SRC_W - 1 - sx;
        my = SRC_H - 1 - sy;
`else
        mx = sx;
        my = sy;
`endif
        return pal_tab[pix(fr, mx, my)];
    endfunction

    task automatic do_line(input int fr, input int ln, input int len);
        @(negedge pclk); hsync = 1'b0;
        @(negedge pclk); hsync = 1'b1;
        for (int c = 0; c < len; c++) begin
            @(negedge pclk);
            de = 1'b1;
            sbq.push_back(exp_color(fr, ln, c));
        end
        @(negedge pclk); de = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
    endtask

    task automatic vs_pulse();
        @(negedge pclk); vsync = 1'b0;
        @(negedge pclk); vsync = 1'b1;
    endtask

    always @(negedge pclk) begin
        if (sb_en) begin
            if (out_de) begin
                if (sbq.size() == 0) chk("sb_underflow", 32'(sbq.size()), 1);
                else chk("color", color, sbq.pop_front());
            end else begin
                chk("blank_color", color, 0);
            end
        end
    end

    initial begin
        tv[0] = '{100, 1};
        tv[1] = '{0, 1};
        tv[2] = '{1, 2};
        tv[3] = '{7, 3};

        rst = 1'b1; in_valid = 1'b0; in_pixel = 2'd0; in_vsync = 1'b0;
        de = 1'b0; hsync = 1'b1; vsync = 1'b1;
        palette = {pal_tab[3], pal_tab[2], pal_tab[1], pal_tab[0]};
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        chk("rst_wb", dut.wb, 0);
        chk("rst_lc", dut.lc, 1);
        chk("rst_rb", dut.rb, 1);
        chk("rst_have", dut.have_frame, 0);
        chk("rst_waddr", dut.waddr, 0);
        chk("rst_color", color, 0);
        chk("rst_out_de", out_de, 0);
        chk("rst_drop", drop_cnt, 0);

        // frame 1 plus surplus pixels that must be ignored
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge pclk);
            in_valid = 1'b1;
            in_pixel = 2'(pix(1, a % SRC_W, a / SRC_W));
        end
        repeat (5) begin
            @(negedge pclk); in_valid = 1'b1; in_pixel = 2'd3;
        end
        @(negedge pclk); in_valid = 1'b0;
        chk("full_waddr", dut.waddr, DEPTH);
        @(negedge pclk); in_vsync = 1'b1; in_valid = 1'b1; in_pixel = 2'd3;
        @(negedge pclk); in_vsync = 1'b0; in_valid = 1'b0;
        chk("f1_lc", dut.lc, 0);
        chk("f1_wb", dut.wb, 2);
        chk("f1_rb", dut.rb, 1);
        chk("f1_have", dut.have_frame, 1);
        chk("f1_waddr_concurrent", dut.waddr, 1);
        chk("f1_drop", drop_cnt, 0);

        sb_en = 1'b1;
        vs_pulse();
        chk("swap1_rb", dut.rb, 0);
        for (int ln = 0; ln < 434; ln++) begin
            do_line(1, ln, (ln < 4 || ln == 200 || ln >= 429) ? 500 : 3);
        end
        repeat (4) @(negedge pclk);
        chk("sb_drain1", 32'(sbq.size()), 0);

        // frame 2 completes in the same cycle as a display vsync fall
        for (int a = 1; a < DEPTH; a++) begin
            @(negedge pclk); in_valid = 1'b1; in_pixel = 2'd2;
        end
        @(negedge pclk); in_valid = 1'b0; in_vsync = 1'b1; vsync = 1'b0;
        @(negedge pclk); in_vsync = 1'b0; vsync = 1'b1;
        chk("coinc_rb", dut.rb, 0);
        chk("coinc_lc", dut.lc, 2);
        chk("coinc_wb", dut.wb, 1);
        vs_pulse();
        chk("swap2_rb", dut.rb, 2);
        chk("swap2_wb", dut.wb, 1);
        for (int ln = 0; ln < 4; ln++) do_line(2, ln, 500);
        repeat (4) @(negedge pclk);
        chk("sb_drain2", 32'(sbq.size()), 0);
        sb_en = 1'b0;

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < tv[t].npix; i++) begin
                @(negedge pclk); in_valid = 1'b1; in_pixel = 2'd1;
            end
            @(negedge pclk); in_valid = 1'b0;
            chk("drop_waddr_pre", dut.waddr, tv[t].npix);
            @(negedge pclk); in_vsync = 1'b1;
            @(negedge pclk); in_vsync = 1'b0;
            chk("drop_cnt", drop_cnt, tv[t].exp_drop);
            chk("drop_waddr", dut.waddr, 0);
            chk("drop_wb", dut.wb, 1);
            chk("drop_lc", dut.lc, 2);
        end
        for (int k = 0; k < 254; k++) begin
            @(negedge pclk); in_valid = 1'b1;
            @(negedge pclk); in_valid = 1'b0; in_vsync = 1'b1;
            @(negedge pclk); in_vsync = 1'b0;
            if (k == 252) chk("drop_sat", drop_cnt, 255);
        end
        chk("drop_sat_hold", drop_cnt, 255);

        // asynchronous reset in the middle of a frame with display active
        for (int i = 0; i < 5000; i++) begin
            @(negedge pclk);
            in_valid = 1'b1;
            in_pixel = 2'd1;
            hsync = (i == 4985) ? 1'b0 : 1'b1;
            de = (i >= 4988);
        end
        @(negedge pclk); in_valid = 1'b0;
        chk("mid_waddr", dut.waddr, 5000);
        chk("mid_out_de", out_de, 1);
        chk("mid_color", color, pal_tab[2]);
        #2 rst = 1'b1;
        #1;
        chk("arst_drop", drop_cnt, 0);
        chk("arst_waddr", dut.waddr, 0);
        chk("arst_color", color, 0);
        chk("arst_out_de", out_de, 0);
        @(negedge pclk); rst = 1'b0; de = 1'b0;
        chk("arst_wb", dut.wb, 0);
        chk("arst_lc", dut.lc, 1);
        chk("arst_rb", dut.rb, 1);
        chk("arst_have", dut.have_frame, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scaled_frame_buffer.md
SCALED_FRAME_BUFFER -- requirements
Module: scaled_frame_buffer

Interface
REQ-001 Parameters (name, default, meaning):
- SRC_W, 160, source pixels per line.
- SRC_H, 144, source lines per frame.
- PIX_W, 2, source pixel width in bits.
- SCALE, 3, integer up-scale factor, applied in both x and y.
- NUM_BUF, 3, frame buffers, range 3..4.
- COLOR_W, 16, output colour width.
REQ-002 Ports (name, direction, width, meaning):
- pclk, in, 1: single clock for the whole block.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: source pixel strobe.
- in_pixel, in, PIX_W: source pixel value.
- in_vsync, in, 1: active-high source frame start.
- palette, in, COLOR_W*2^PIX_W: palette; entry i occupies bits [i*COLOR_W +: COLOR_W].
- de, in, 1: display data-enable.
- hsync, in, 1: display horizontal sync, active-low.
- vsync, in, 1: display vertical sync, active-low.
- color, out, COLOR_W: output pixel colour.
- out_de, out, 1: de delayed to align with color.
- drop_cnt, out, 8: count of discarded incomplete frames.

Function
REQ-003 Storage SHALL be NUM_BUF internal arrays of SRC_W*SRC_H entries, PIX_W bits each, all in the pclk domain.
REQ-004 Write side: on each in_valid cycle with waddr < SRC_W*SRC_H, in_pixel SHALL be written to buffer wb at waddr, and waddr SHALL increment.
REQ-005 in_valid with waddr = SRC_W*SRC_H SHALL be ignored (no wrap).
REQ-006 in_vsync rising edge with waddr = SRC_W*SRC_H (frame complete): lc <= wb; have_frame <= 1; wb <= lowest index not equal to rb and not equal to the new lc; waddr <= 0.
REQ-007 in_vsync rising edge with 0 < waddr < SRC_W*SRC_H: frame discarded; wb unchanged; waddr <= 0; drop_cnt increments, saturating at 255.
REQ-008 in_vsync rising edge with waddr = 0: no action.
REQ-009 in_valid in the same cycle as an in_vsync rising edge SHALL be written at address 0 of the resulting wb, and waddr SHALL become 1.
REQ-010 Read swap: on each vsync falling edge (vsync sampled at pclk), rb <= lc, and the display counters x, xs, y, ys SHALL clear.
REQ-011 If a frame completes in the same cycle as a vsync falling edge, rb SHALL take the pre-update lc; the new frame is shown at the next vsync.
REQ-012 wb SHALL never equal rb or lc after any update.
REQ-013 hsync falling edge SHALL clear x and xs.
REQ-014 Horizontal counters: on each de cycle, xs increments modulo SCALE; x increments when xs wraps, and saturates at SRC_W.
REQ-015 Vertical counters: on the de falling edge, ys increments modulo SCALE; y increments when ys wraps, and saturates at SRC_H.
REQ-016 Active area: x < SRC_W and y < SRC_H.
REQ-017 Read address SHALL be y*SRC_W + x, computed at width clog2(SRC_W*SRC_H); no modulo arithmetic.
REQ-018 Latency: memory read registered (1 cycle), then palette lookup registered (1 cycle), giving color 2 pclk after the de sample; out_de is de delayed 2 cycles.
REQ-019 color SHALL be palette entry [pixel] when the sample was active and have_frame = 1; otherwise it SHALL be 0.

Reset
REQ-020 rst SHALL set:
- waddr = 0, wb = 0, lc = 1, rb = 1, have_frame = 0.
- x, xs, y, ys = 0.
- drop_cnt = 0, color = 0, out_de = 0.
- all edge-detect registers: in_vsync = 0, hsync = 1, vsync = 1, de = 0.
REQ-021 Buffer contents are not reset.
REQ-022 Reset mid-frame SHALL abandon the partial frame without incrementing drop_cnt.

Configuration
REQ-023 Macro SCALED_FRAME_BUFFER_ROTATE_180_EN:
- Defined: read address = (SRC_H-1-y)*SRC_W + (SRC_W-1-x), giving a 180-degree rotated display.
- Undefined: address per REQ-017.
- Latency and blanking SHALL be identical in both builds.

Verification
REQ-024 Reset, then 23040 in_valid pixels of value 2 and an in_vsync pulse -> lc=0, wb=2, have_frame=1; after the next vsync falling edge, active color = palette[2], 2 cycles after de.
REQ-025 100 pixels then an in_vsync pulse -> drop_cnt=1, wb unchanged, waddr=0; 256 such frames -> drop_cnt=255.
REQ-026 Frame completion and a vsync falling edge in the same cycle -> rb = old lc; next vsync -> rb = new lc; wb is distinct from both throughout.
REQ-027 Display line of 500 de cycles -> each source x repeated 3 cycles; cycles 480..499 color=0; each source line repeated on 3 display lines; lines 432+ color=0.
REQ-028 With ROTATE_180_EN and pixel 0 = 1, all other pixels = 0 -> color = palette[1] only at display x 477..479, lines 429..431.
REQ-029 Assert rst mid-write at waddr=5000 -> drop_cnt=0, waddr=0, color=0, out_de=0 immediately (asynchronous).
